// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared state encoding and widths for the reset sequencer
package rst_sequencer_pkg;

  // STATE encoding as seen on the debug port; decoders elsewhere rely on these values
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_sync_ff.sv
// rtl/rst_sequencer_sync_ff.sv - multi-flop synchroniser with asynchronous clear
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift the input through STAGES flops; clear drops the whole chain at once
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged active-low reset release behind PLL lock
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 128,
  parameter int STAGE_GAP   = 16,
  parameter int LOCK_FILT   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOCKED,
  input  logic                  SOFT_RST,
  output logic [NUM_OUT-1:0]    RST_X_O,
  output logic                  READY,
  output logic [1:0]            STATE,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int STG_W = $clog2(NUM_OUT + 1);
  localparam int LOW_W = $clog2(LOCK_FILT + 1);
  localparam logic [NUM_OUT-1:0] W_ONE = NUM_OUT'(1);

  generate
    if (NUM_OUT < 1) begin : g_bad_num_out
      $error("rst_sequencer: NUM_OUT must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("rst_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
      $error("rst_sequencer: STAGE_GAP must be >= 1");
    end
    if (LOCK_FILT < 1) begin : g_bad_filt
      $error("rst_sequencer: LOCK_FILT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_sequencer: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic                  w_locked_s;
  logic                  w_rst_rel;
  logic                  w_in_seq;
  logic                  w_loss;
  logic [LOW_W-1:0]      w_lowcnt_nxt;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [STG_W-1:0]      r_stage;
  logic [LOW_W-1:0]      r_lowcnt;
  logic [NUM_OUT-1:0]    r_rst_x;
  logic                  r_ready;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_lock_sync (
    .i_clk (CLK),
    .i_clr (RST),
    .i_d   (LOCKED),
    .o_q   (w_locked_s)
  );

  // Release of RST is only seen by the FSM once it has crossed this chain
  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_rst_sync (
    .i_clk (CLK),
    .i_clr (RST),
    .i_d   (1'b1),
    .o_q   (w_rst_rel)
  );

  // Next value of the consecutive-low counter and the resulting loss decision
  always_comb begin
    w_lowcnt_nxt = r_lowcnt;
    if (w_locked_s) begin
      w_lowcnt_nxt = '0;
    end else if (r_lowcnt != LOW_W'(LOCK_FILT)) begin
      w_lowcnt_nxt = r_lowcnt + LOW_W'(1);
    end
    w_in_seq = (r_state != WAIT_LOCK);
    w_loss   = w_in_seq && (w_lowcnt_nxt == LOW_W'(LOCK_FILT));
  end

  // Saturating run length of low synced-lock samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lowcnt <= '0;
    end else if (w_rst_rel) begin
      r_lowcnt <= w_lowcnt_nxt;
    end
  end

  // Sequencer FSM: loss beats soft reset, which beats normal progress
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_rst_x    <= '0;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else if (w_rst_rel) begin
      if (w_loss) begin
        r_state <= WAIT_LOCK;
        r_cnt   <= '0;
        r_stage <= '0;
        r_rst_x <= '0;
        r_ready <= 1'b0;
        if (r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
      end else if (w_in_seq && SOFT_RST) begin
        r_state <= HOLD;
        r_cnt   <= '0;
        r_stage <= '0;
        r_rst_x <= '0;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            if (w_locked_s) begin
              r_state <= HOLD;
              r_cnt   <= '0;
            end
          end
          HOLD: begin
            if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              r_cnt   <= '0;
              r_stage <= '0;
              if (NUM_OUT == 1) begin
                r_state <= RUN;
                r_rst_x <= '1;
                r_ready <= 1'b1;
              end else begin
                r_state <= RELEASE;
                r_rst_x <= W_ONE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
              r_cnt   <= '0;
              r_stage <= r_stage + STG_W'(1);
              // shifting in a one keeps releases strictly in index order
              r_rst_x <= (r_rst_x << 1) | W_ONE;
              if (r_stage == STG_W'(NUM_OUT - 2)) begin
                r_state <= RUN;
                r_ready <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RUN: begin
          end
          default: r_state <= WAIT_LOCK;
        endcase
      end
    end
  end

  assign RST_X_O  = r_rst_x;
  assign READY    = r_ready;
  assign STATE    = r_state;
  assign LOSS_CNT = r_loss_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for the staged reset sequencer
module tb_rst_sequencer;

  localparam int NUM   = 3;
  localparam int HOLDC = 128;
  localparam int GAP   = 16;
  localparam int FILT  = 4;
  localparam int SYNC  = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           LOCKED = 1'b0;
  logic           SOFT_RST = 1'b0;
  logic [NUM-1:0] RST_X_O;
  logic           READY;
  logic [1:0]     STATE;
  logic [7:0]     LOSS_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [NUM-1:0] rx;
    logic           rdy;
    logic [1:0]     st;
    logic [7:0]     lc;
  } exp_t;

  exp_t exp_q[$];

  rst_sequencer #(
    .NUM_OUT(NUM), .HOLD_CYCLES(HOLDC), .STAGE_GAP(GAP),
    .LOCK_FILT(FILT), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOCKED   (LOCKED),
    .SOFT_RST (SOFT_RST),
    .RST_X_O  (RST_X_O),
    .READY    (READY),
    .STATE    (STATE),
    .LOSS_CNT (LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: time since the sequence (re)started decides how many outputs are free
  int  lk_q[$];
  int  rel_cnt;
  bit  in_seq;
  int  t_seq;
  int  lowrun;
  int  mlc;

  always @(posedge CLK) begin : model
    int   ls;
    int   nrel;
    exp_t e;
    if (RST) begin
      lk_q = {};
      for (int i = 0; i < SYNC; i++) lk_q.push_back(0);
      rel_cnt = 0;
      in_seq  = 0;
      t_seq   = 0;
      lowrun  = 0;
      mlc     = 0;
    end else begin
      ls = lk_q.pop_front();
      lk_q.push_back(int'(LOCKED));
      if (rel_cnt < SYNC) begin
        rel_cnt++;
      end else begin
        lowrun = (ls != 0) ? 0 : ((lowrun < FILT) ? lowrun + 1 : FILT);
        if (in_seq) begin
          if (lowrun >= FILT) begin
            in_seq = 0;
            if (mlc < 255) mlc++;
          end else if (SOFT_RST) begin
            t_seq = 0;
          end else if (t_seq < 100000) begin
            t_seq++;
          end
        end else if (ls != 0) begin
          in_seq = 1;
          t_seq  = 0;
        end
      end
    end
    nrel = 0;
    if (in_seq && t_seq >= HOLDC) nrel = 1 + (t_seq - HOLDC) / GAP;
    if (nrel > NUM) nrel = NUM;
    e.rx  = NUM'((1 << nrel) - 1);
    e.rdy = in_seq && (nrel == NUM);
    e.st  = !in_seq ? 2'd0 : (nrel == 0) ? 2'd1 : (nrel == NUM) ? 2'd3 : 2'd2;
    e.lc  = 8'(mlc);
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a full output set to compare against the queue head
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({RST_X_O, READY, STATE, LOSS_CNT} === {e.rx, e.rdy, e.st, e.lc}) n_pass++;
      else $display("FAIL outputs @%0t: got rst_x=%b ready=%b state=%0d loss=%0d, expected rst_x=%b ready=%b state=%0d loss=%0d",
                    $time, RST_X_O, READY, STATE, LOSS_CNT, e.rx, e.rdy, e.st, e.lc);
    end
  end

  task automatic step(input bit lk, input bit sr);
    @(negedge CLK);
    #2;
    LOCKED   = lk;
    SOFT_RST = sr;
  endtask

  initial begin
    bit lk;
    int waited;

    // power-on reset with lock already present, then full staged release
    RST = 1'b1;
    LOCKED = 1'b1;
    repeat (10) step(1, 0);
    @(negedge CLK); #2; RST = 1'b0;
    repeat (200) step(1, 0);

    // short glitch below the filter threshold
    repeat (3) step(0, 0);
    repeat (20) step(1, 0);

    // filtered loss, then the whole sequence again
    repeat (6) step(0, 0);
    repeat (200) step(1, 0);

    // soft reset in RUN, then soft reset while waiting for lock
    step(1, 1);
    repeat (200) step(1, 0);
    repeat (8) step(0, 0);
    step(0, 1);
    repeat (5) step(0, 0);
    repeat (200) step(1, 0);

    // asynchronous reset while only the first output is released
    @(negedge CLK); #2; RST = 1'b1;
    repeat (3) step(1, 0);
    @(negedge CLK); #2; RST = 1'b0;
    waited = 0;
    while (RST_X_O != 3'b001 && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("reach_001", int'(RST_X_O), 1);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_x", int'(RST_X_O), 0);
    chk("async_ready", int'(READY), 0);
    chk("async_loss_cnt", int'(LOSS_CNT), 0);
    chk("async_state", int'(STATE), 0);
    repeat (3) step(1, 0);
    @(negedge CLK); #2; RST = 1'b0;

    // repeated filtered losses, some coinciding with a soft reset
    for (int k = 0; k < 262; k++) begin
      repeat (4) step(1, 0);
      for (int j = 0; j < 6; j++)
        step(0, ((j == 5) && (k % 3 == 0)) || ($urandom_range(0, 15) == 0));
    end
    repeat (3) step(0, 0);
    chk("loss_saturated", int'(LOSS_CNT), 255);
    chk("loss_state", int'(STATE), 0);

    // random lock flicker and soft resets
    lk = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      step(lk, $urandom_range(0, 59) == 0);
    end
    repeat (3) step(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
